// File: rtl/store_buffer_if.sv
// Load/store port between the MEM stage (master) and the store buffer (slave).
interface store_buffer_if;
  logic        st_valid;
  logic [31:0] st_address;
  logic [31:0] st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_address;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        empty;

  modport master (output st_valid, st_address, st_data, ld_valid, ld_address,
                  input  st_ready, ld_ready, ld_data, empty);
  modport slave  (input  st_valid, st_address, st_data, ld_valid, ld_address,
                  output st_ready, ld_ready, ld_data, empty);
endinterface

// File: rtl/store_buffer.sv
// Posted-write FIFO between MEM stage and single-port data memory; drains on
// cycles without a load and forwards the youngest matching store to loads.
//
//   arb mode       | meaning
//   ARB_IDLE       | nothing buffered, no load; memory port idle
//   ARB_LOAD       | load owns the memory port; buffer holds
//   ARB_DRAIN      | no load this cycle; oldest entry written to memory
//   ARB_DRAIN_FULL | buffer full; oldest entry forced out, load and store stalled
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  store_buffer_if.slave bus,
  output logic [31:0]   mem_address,
  output logic [31:0]   mem_write_data,
  output logic          mem_write,
  input  logic [31:0]   mem_read_data
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_LOAD,
    ARB_DRAIN,
    ARB_DRAIN_FULL
  } arb_e;

  logic [29:0]      addr_q [DEPTH];
  logic [29:0]      addr_d [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  arb_e             arb;
  logic             full;
  logic             push;
  logic             pop;
  logic [31:0]      fwd_data;
  logic [PTR_W-1:0] idx;
  logic             unused_addr_lsbs;

  assign unused_addr_lsbs = ^{bus.st_address[1:0], bus.ld_address[1:0]};

  always_comb begin
    full = (count_q == FULL_CNT);
    if (full)
      arb = ARB_DRAIN_FULL;
    else if (bus.ld_valid)
      arb = ARB_LOAD;
    else if (count_q != '0)
      arb = ARB_DRAIN;
    else
      arb = ARB_IDLE;
    pop  = (arb == ARB_DRAIN) || (arb == ARB_DRAIN_FULL);
    push = bus.st_valid && !full;
  end

  assign bus.st_ready   = !full;
  assign bus.ld_ready   = !full;
  assign bus.empty      = (count_q == '0);
  assign mem_write      = pop;
  assign mem_write_data = data_q[head_q];
  assign mem_address    = pop ? {addr_q[head_q], 2'b00} : bus.ld_address;

  // Walk entries oldest to youngest so the last match wins; the head is
  // still included while it drains.
  always_comb begin
    fwd_data = mem_read_data;
    idx      = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (addr_q[idx] == bus.ld_address[31:2]))
        fwd_data = data_q[idx];
    end
  end

  assign bus.ld_data = fwd_data;

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    tail_d = tail_q;
    head_d = head_q;
    if (push) begin
      addr_d[tail_q] = bus.st_address[31:2];
      data_d[tail_q] = bus.st_data;
      tail_d         = tail_q + PTR_W'(1);
    end
    if (pop)
      head_d = head_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload needs no reset: validity comes from count alone.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end
endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: a queue-based reference model predicts
// per-cycle handshakes, load results and the ordered memory write stream.
module tb_store_buffer;
  localparam int DEPTH = 4;

  typedef struct packed { logic [31:0] a; logic [31:0] d; } ent_t;
  typedef struct packed { logic st_r; logic ld_r; logic mw; logic emp; } ctl_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic [31:0] mem_read_data;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic        mem_inited = 1'b0;

  ent_t        pend[$];
  ent_t        exp_wr_q[$];
  logic [31:0] exp_ld_q[$];
  ctl_t        exp_ctl_q[$];

  int errors = 0;
  int checks = 0;

  store_buffer_if sbif();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (sbif),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_address[9:2]];

  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + 32'(i);
      mem_inited <= 1'b1;
    end else if (mem_write) begin
      mem[mem_address[9:2]] <= mem_write_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // One modelled cycle: drive inputs, predict this cycle, then advance the model.
  task automatic step(input logic stv, input logic [31:0] sta, input logic [31:0] std,
                      input logic ldv, input logic [31:0] lda);
    int          n;
    logic        full;
    logic        drain;
    logic [31:0] ld_exp;
    ctl_t        c;
    @(posedge clk);
    #1;
    sbif.st_valid   = stv;
    sbif.st_address = sta;
    sbif.st_data    = std;
    sbif.ld_valid   = ldv;
    sbif.ld_address = lda;
    n     = pend.size();
    full  = (n == DEPTH);
    drain = full || (!ldv && n > 0);
    c.st_r = !full;
    c.ld_r = !full;
    c.mw   = drain;
    c.emp  = (n == 0);
    exp_ctl_q.push_back(c);
    if (ldv && !full) begin
      ld_exp = ref_mem[lda[9:2]];
      foreach (pend[i]) if (pend[i].a[31:2] == lda[31:2]) ld_exp = pend[i].d;
      exp_ld_q.push_back(ld_exp);
    end
    if (drain) begin
      ref_mem[pend[0].a[9:2]] = pend[0].d;
      exp_wr_q.push_back(pend[0]);
      void'(pend.pop_front());
    end
    if (stv && !full) pend.push_back('{a: sta, d: std});
  endtask

  always @(negedge clk) begin
    ctl_t        c;
    ent_t        w;
    logic [31:0] e;
    if (exp_ctl_q.size() > 0) begin
      c = exp_ctl_q.pop_front();
      chk("st_ready",  32'(sbif.st_ready), 32'(c.st_r));
      chk("ld_ready",  32'(sbif.ld_ready), 32'(c.ld_r));
      chk("mem_write", 32'(mem_write),     32'(c.mw));
      chk("empty",     32'(sbif.empty),    32'(c.emp));
      if (sbif.ld_valid && sbif.ld_ready) begin
        if (exp_ld_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ld_unexpected: got load at %08h expected none", sbif.ld_address);
        end else begin
          e = exp_ld_q.pop_front();
          chk("ld_data", sbif.ld_data, e);
        end
      end
      if (mem_write) begin
        if (exp_wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_unexpected: got write %08h to %08h expected none", mem_write_data, mem_address);
        end else begin
          w = exp_wr_q.pop_front();
          chk("wr_addr", mem_address, {w.a[31:2], 2'b00});
          chk("wr_data", mem_write_data, w.d);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nmis;
    reset           = 1'b0;
    sbif.st_valid   = 1'b0;
    sbif.st_address = '0;
    sbif.st_data    = '0;
    sbif.ld_valid   = 1'b0;
    sbif.ld_address = 32'h30;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'hA000_0000 + 32'(i);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_empty",     32'(sbif.empty),    32'd1);
    chk("rst_st_ready",  32'(sbif.st_ready), 32'd1);
    chk("rst_ld_ready",  32'(sbif.ld_ready), 32'd1);
    chk("rst_mem_write", 32'(mem_write),     32'd0);
    chk("rst_ld_data",   sbif.ld_data,       ref_mem[12]);
    #2 reset = 1'b1;
    step(1'b0, 32'h0, 32'h0, 1'b0, 32'h30);

    // store then drain
    step(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("mem_word4", mem[4], 32'hDEAD_BEEF);

    // youngest-match forwarding while loads block draining
    step(1'b1, 32'h20, 32'h11, 1'b1, 32'h100);
    step(1'b1, 32'h20, 32'h22, 1'b1, 32'h100);
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h20);
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h23);
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h24);
    repeat (3) step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

    // fill, forced drain with a store pending, then accept it
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'h80 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 1'b1, 32'h200);
    step(1'b1, 32'h90, 32'h5555_AAAA, 1'b1, 32'h80);
    step(1'b1, 32'h90, 32'h5555_AAAA, 1'b1, 32'h84);
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h90);
    repeat (5) step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

    // wrap-around: distinct stores interleaved with loads of earlier words
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h40 + 32'(4 * i), $urandom, 1'b1, 32'h40);
      step(1'b0, 32'h0, 32'h0, 1'b1, 32'h40 + 32'(4 * $urandom_range(0, i)));
    end
    repeat (6) step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

    // randomized traffic over a small set of words
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)),
           32'h40 + 32'(4 * $urandom_range(0, 9)) + 32'($urandom_range(0, 3)),
           $urandom,
           ($urandom_range(0, 9) < 6),
           32'h40 + 32'(4 * $urandom_range(0, 9)) + 32'($urandom_range(0, 3)));
    repeat (6) step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

    // reset with three stores pending
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h70 + 32'(4 * i), 32'hBAD0_0000 + 32'(i), 1'b1, 32'h40);
    @(posedge clk);
    #1;
    sbif.st_valid = 1'b0;
    sbif.ld_valid = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("midrst_empty",     32'(sbif.empty),    32'd1);
    chk("midrst_mem_write", 32'(mem_write),     32'd0);
    chk("midrst_st_ready",  32'(sbif.st_ready), 32'd1);
    pend.delete();
    @(posedge clk);
    #3 reset = 1'b1;
    repeat (6) step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

    @(negedge clk);
    nmis = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nmis++;
    chk("mem_image_mismatches", 32'(nmis), 32'd0);
    chk("leftover_writes", 32'(exp_wr_q.size()), 32'd0);
    chk("leftover_loads",  32'(exp_ld_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
